// File: rtl/ysyx_25020047_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_25020047_ifu
//  Brief    : Non-pipelined instruction fetch unit: owns the PC, fetches one
//             word per PC, issues it to decode, waits for write-back's dnpc.
//  Revision : 1.0
// ============================================================================
module ysyx_25020047_ifu #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid,
    output logic [XLEN-1:0] req_addr,
    input  logic            req_ready,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    input  logic            rsp_err,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] snpc,
    input  logic            inst_ready,
    input  logic            wb_valid,
    input  logic [XLEN-1:0] wb_dnpc,
    output logic            wb_ready,
    output logic            fault,
    output logic [1:0]      fault_code
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RESP  = 3'd2,
        S_ISSUE = 3'd3,
        S_WB    = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [1:0]      c_FAULT_NONE  = 2'd0;
    localparam logic [1:0]      c_FAULT_ALIGN = 2'd1;
    localparam logic [1:0]      c_FAULT_RSP   = 2'd2;
    localparam logic [XLEN-1:0] c_INST_STEP   = XLEN'(4);

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;
    logic            r_req_valid;
    logic            r_inst_valid;
    logic            r_wb_ready;
    logic            r_fault;
    logic [1:0]      r_fault_code;

    // Handshake outputs are flops updated with the state, so no input reaches them combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
            r_wb_ready   <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= c_FAULT_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state     <= S_REQ;
                    r_req_valid <= 1'b1;
                end
                S_REQ: begin
                    if (req_ready) begin
                        r_state     <= S_RESP;
                        r_req_valid <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (rsp_valid) begin
                        if (rsp_err) begin
                            r_state      <= S_FAULT;
                            r_fault      <= 1'b1;
                            r_fault_code <= c_FAULT_RSP;
                        end else begin
                            r_state      <= S_ISSUE;
                            r_inst       <= rsp_data;
                            r_inst_valid <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (inst_ready) begin
                        r_state      <= S_WB;
                        r_inst_valid <= 1'b0;
                        r_wb_ready   <= 1'b1;
                    end
                end
                S_WB: begin
                    if (wb_valid) begin
                        r_wb_ready <= 1'b0;
                        if (wb_dnpc[1:0] == 2'b00) begin
                            r_state     <= S_REQ;
                            r_pc        <= wb_dnpc;
                            r_req_valid <= 1'b1;
                        end else begin
                            r_state      <= S_FAULT;
                            r_fault      <= 1'b1;
                            r_fault_code <= c_FAULT_ALIGN;
                        end
                    end
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_req_valid  <= 1'b0;
                    r_inst_valid <= 1'b0;
                    r_wb_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign req_valid  = r_req_valid;
    assign req_addr   = r_pc;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign pc         = r_pc;
    assign snpc       = r_pc + c_INST_STEP;
    assign wb_ready   = r_wb_ready;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

endmodule
`default_nettype wire
